// File: rtl/auth_tx.sv
// auth_tx: 8N1 UART sender for 'g'/'s' auth commands; ports clk, rst, go_req, stop_req -> TX, busy, tx_done, pend_valid, cmd_dropped
module auth_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic clk,
  input  logic rst,
  input  logic go_req,
  input  logic stop_req,
  output logic TX,
  output logic busy,
  output logic tx_done,
  output logic pend_valid,
  output logic cmd_dropped
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);
  state_t r_state, w_state_nxt;
  logic [15:0] r_baud, w_baud_nxt;
  logic [2:0] r_bit, w_bit_nxt;
  logic [7:0] r_shift, w_shift_nxt, r_pend_byte, w_pend_byte_nxt;
  logic r_pend, w_pend_nxt, r_drop, w_drop_nxt, r_tx, w_tx_nxt;
  logic w_req, w_bend;
  logic [7:0] w_byte;
  assign w_req = go_req | stop_req;
  assign w_byte = stop_req ? 8'h73 : 8'h67;
  assign w_bend = r_baud == LAST;
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt = w_bend ? 16'd0 : r_baud + 16'd1;
    w_bit_nxt = r_bit;
    w_shift_nxt = r_shift;
    w_pend_byte_nxt = r_pend_byte;
    w_pend_nxt = r_pend;
    w_drop_nxt = 1'b0;
    if (w_req && r_state != IDLE) begin
      w_pend_byte_nxt = w_byte;
      w_pend_nxt = 1'b1;
      w_drop_nxt = r_pend;
    end
    case (r_state)
      IDLE: begin
        w_baud_nxt = '0;
        w_bit_nxt = '0;
        // an idle-time request over a full slot overwrites it, and the new byte launches at once
        if (r_pend || w_req) begin
          w_shift_nxt = w_req ? w_byte : r_pend_byte;
          w_pend_nxt = 1'b0;
          w_drop_nxt = r_pend && w_req;
          w_state_nxt = START;
        end
      end
      START: w_state_nxt = w_bend ? DATA : START;
      DATA: if (w_bend) begin
        w_shift_nxt = r_shift >> 1;
        w_bit_nxt = r_bit + 3'd1;
        w_state_nxt = r_bit == 3'd7 ? STOP : DATA;
      end
      STOP: w_state_nxt = w_bend ? IDLE : STOP;
      default: w_state_nxt = IDLE;
    endcase
    // line level is registered from the next state so TX is a clean flop output
    w_tx_nxt = w_state_nxt == START ? 1'b0 : w_state_nxt == DATA ? w_shift_nxt[0] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_pend_byte <= '0;
      r_pend <= 1'b0;
      r_drop <= 1'b0;
      r_tx <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud <= w_baud_nxt;
      r_bit <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_pend_byte <= w_pend_byte_nxt;
      r_pend <= w_pend_nxt;
      r_drop <= w_drop_nxt;
      r_tx <= w_tx_nxt;
    end
  end
  assign TX = r_tx;
  assign busy = r_state != IDLE;
  assign tx_done = r_state == STOP && w_bend;
  assign pend_valid = r_pend;
  assign cmd_dropped = r_drop;
endmodule

// File: tb/tb_auth_tx.sv
// tb_auth_tx: scoreboard bench for auth_tx at BAUD_DIV=4 and 2604
module tb_auth_tx;
  localparam int B = 4;
  localparam int BL = 2604;
  logic clk = 1'b0, rst = 1'b1, go = 1'b0, stop = 1'b0, go2 = 1'b0, stop2 = 1'b0;
  logic tx4, busy4, done4, pend4, drop4, tx2, busy2, done2, pend2, drop2;
  int checks = 0, errors = 0, frames4 = 0, drops4 = 0, rx2 = 0;
  logic [7:0] q4[$], q2[$];
  always #5 clk = ~clk;
  auth_tx #(.BAUD_DIV(B)) dut4 (.clk(clk), .rst(rst), .go_req(go), .stop_req(stop), .TX(tx4),
    .busy(busy4), .tx_done(done4), .pend_valid(pend4), .cmd_dropped(drop4));
  auth_tx #(.BAUD_DIV(BL)) dut (.clk(clk), .rst(rst), .go_req(go2), .stop_req(stop2), .TX(tx2),
    .busy(busy2), .tx_done(done2), .pend_valid(pend2), .cmd_dropped(drop2));
  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask
  int fc = 0, bad = 0;
  logic [7:0] ex = 0, rx = 0;
  logic pb = 0;
  always @(negedge clk) begin
    if (drop4) drops4++;
    if (rst) begin
      fc = 0;
      pb = 0;
    end else begin
      if (busy4) begin
        fc++;
        if (fc == 1) begin
          bad = 0;
          if (q4.size() == 0) begin
            chk("unexpected_frame", 1, 0);
            ex = 0;
          end else ex = q4.pop_front();
        end
        if (fc <= B) begin
          if (tx4 !== 1'b0) bad++;
        end else if (fc <= 9 * B) begin
          if (tx4 !== ex[(fc - 1) / B - 1]) bad++;
        end else if (tx4 !== 1'b1) bad++;
        if (done4 !== (fc == 10 * B)) bad++;
        if (fc > B && fc <= 9 * B && (fc - 1) % B == B / 2) rx = {tx4, rx[7:1]};
        if (done4) begin
          chk("frame_byte", int'(rx), int'(ex));
          chk("frame_shape_errs", bad, 0);
          frames4++;
        end
      end else if (pb) begin
        chk("frame_len", fc, 10 * B);
        fc = 0;
      end
      pb = busy4;
    end
  end
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && tx2 === 1'b0) begin
        repeat (BL / 2) @(negedge clk);
        chk("rx_start_mid", int'(tx2), 0);
        for (int k = 0; k < 8; k++) begin
          repeat (BL) @(negedge clk);
          b[k] = tx2;
        end
        repeat (BL) @(negedge clk);
        chk("rx_stop_bit", int'(tx2), 1);
        if (q2.size() == 0) chk("rx_unexpected", int'(b), -1);
        else chk("rx_byte", int'(b), int'(q2.pop_front()));
        rx2++;
      end
    end
  end
  task automatic pulse(input logic g, input logic s);
    @(posedge clk);
    #1 go = g;
    stop = s;
    @(posedge clk);
    #1 go = 1'b0;
    stop = 1'b0;
  endtask
  task automatic quiet(input int lim);
    int n = 0;
    while ((busy4 || pend4) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (busy4 || pend4) chk("quiet_timeout", n, -1);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    int d, f, n;
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(tx4), 1);
    chk("rst_busy", int'(busy4), 0);
    chk("rst_done", int'(done4), 0);
    chk("rst_pend", int'(pend4), 0);
    chk("rst_drop", int'(drop4), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    q4.push_back(8'h67);
    pulse(1, 0);
    chk("tx_low_n1", int'(tx4), 0);
    chk("busy_n1", int'(busy4), 1);
    quiet(200);
    chk("frames_go", frames4, 1);
    q4.push_back(8'h73);
    pulse(0, 1);
    quiet(200);
    d = drops4;
    q4.push_back(8'h73);
    pulse(1, 1);
    quiet(200);
    chk("both_no_drop", drops4, d);
    chk("frames_both", frames4, 3);
    q4.push_back(8'h73);
    pulse(0, 1);
    repeat (8) @(posedge clk);
    q4.push_back(8'h67);
    pulse(1, 0);
    chk("pend_set", int'(pend4), 1);
    n = 0;
    while (!done4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", int'(done4), 1);
    @(negedge clk);
    chk("gap_busy", int'(busy4), 0);
    chk("gap_tx", int'(tx4), 1);
    chk("gap_pend", int'(pend4), 1);
    @(negedge clk);
    chk("launch_busy", int'(busy4), 1);
    chk("launch_tx", int'(tx4), 0);
    chk("launch_pend", int'(pend4), 0);
    quiet(200);
    chk("frames_pend", frames4, 5);
    q4.push_back(8'h67);
    pulse(1, 0);
    d = drops4;
    repeat (3) @(posedge clk);
    pulse(1, 0);
    repeat (3) @(posedge clk);
    q4.push_back(8'h73);
    pulse(0, 1);
    chk("ovw_pend", int'(pend4), 1);
    quiet(300);
    chk("ovw_drops", drops4, d + 1);
    chk("frames_ovw", frames4, 7);
    q4.push_back(8'h67);
    f = frames4;
    pulse(1, 0);
    repeat (3) @(posedge clk);
    pulse(1, 0);
    chk("rst_test_pend", int'(pend4), 1);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q4.delete();
    chk("trunc_tx", int'(tx4), 1);
    chk("trunc_busy", int'(busy4), 0);
    chk("trunc_pend", int'(pend4), 0);
    repeat (50) @(negedge clk);
    chk("trunc_no_done", frames4, f);
    q4.push_back(8'h67);
    pulse(1, 0);
    quiet(200);
    chk("frames_clean", frames4, f + 1);
    q2.push_back(8'h67);
    q2.push_back(8'h73);
    @(posedge clk);
    #1 go2 = 1'b1;
    @(posedge clk);
    #1 go2 = 1'b0;
    repeat (100) @(posedge clk);
    #1 stop2 = 1'b1;
    @(posedge clk);
    #1 stop2 = 1'b0;
    n = 0;
    while (rx2 < 2 && n < 60000) begin
      @(negedge clk);
      n++;
    end
    chk("rx2_count", rx2, 2);
    chk("q4_empty", q4.size(), 0);
    chk("q2_empty", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
